// File: rtl/window_scan_counter.sv
// 2-D programmable scan counter: walks (x, y) over a runtime-configured window,
// with per-axis reverse scan, optional frame looping and line/frame terminal pulses.
module window_scan_counter #(
  parameter  int unsigned H_MAX = 240,
  parameter  int unsigned V_MAX = 320,
  localparam int unsigned X_W   = $clog2(H_MAX),
  localparam int unsigned Y_W   = $clog2(V_MAX)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [X_W-1:0] x_start,
  input  logic [X_W-1:0] x_end,
  input  logic [Y_W-1:0] y_start,
  input  logic [Y_W-1:0] y_end,
  input  logic           x_rev,
  input  logic           y_rev,
  input  logic           loop,
  input  logic           abort,
  input  logic           step,
  output logic           busy,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           eol,
  output logic           eof,
  output logic           cfg_err
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t         state;
  logic [X_W-1:0] xs_q, xe_q;
  logic [Y_W-1:0] ys_q, ye_q;
  logic           xr_q, yr_q, loop_q;

  logic           cfg_ok;
  logic [X_W-1:0] x_org, x_term, x_adv;
  logic [Y_W-1:0] y_org, y_term, y_adv;
  logic           row_end, last_row;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  assign cfg_ok = (x_start <= x_end) && (32'(x_end) < H_MAX) &&
                  (y_start <= y_end) && (32'(y_end) < V_MAX);

  // Scan origin and terminal per axis, flipped by the latched reverse bits
  assign x_org  = xr_q ? xe_q : xs_q;
  assign x_term = xr_q ? xs_q : xe_q;
  assign y_org  = yr_q ? ye_q : ys_q;
  assign y_term = yr_q ? ys_q : ye_q;

  // Only used away from the terminal, so never steps outside the window
  assign x_adv = xr_q ? (x - X_W'(1)) : (x + X_W'(1));
  assign y_adv = yr_q ? (y - Y_W'(1)) : (y + Y_W'(1));

  assign row_end  = (x == x_term);
  assign last_row = (y == y_term);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      eol     <= 1'b0;
      eof     <= 1'b0;
      cfg_err <= 1'b0;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
      xr_q    <= 1'b0;
      yr_q    <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      eol     <= 1'b0;
      eof     <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              xs_q   <= x_start;
              xe_q   <= x_end;
              ys_q   <= y_start;
              ye_q   <= y_end;
              xr_q   <= x_rev;
              yr_q   <= y_rev;
              loop_q <= loop;
              x      <= x_rev ? x_end : x_start;
              y      <= y_rev ? y_end : y_start;
              state  <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (step) begin
            if (!row_end) begin
              x <= x_adv;
            end else if (!last_row) begin
              eol <= 1'b1;
              x   <= x_org;
              y   <= y_adv;
            end else begin
              eol <= 1'b1;
              eof <= 1'b1;
              // Non-looping frames park on the last pixel
              if (loop_q) begin
                x <= x_org;
                y <= y_org;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_scan_counter.sv
// Self-checking bench for window_scan_counter: directed scenarios plus random
// traffic, compared every cycle against a coordinate-list reference model.
module tb_window_scan_counter;

  localparam int unsigned H_MAX = 240;
  localparam int unsigned V_MAX = 320;
  localparam int unsigned X_W   = $clog2(H_MAX);
  localparam int unsigned Y_W   = $clog2(V_MAX);

  logic           clk = 1'b0;
  logic           reset, cfg_valid, cfg_ready;
  logic [X_W-1:0] x_start, x_end, x;
  logic [Y_W-1:0] y_start, y_end, y;
  logic           x_rev, y_rev, loop, abort, step;
  logic           busy, eol, eof, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the window is flattened into a list of pixels in scan order
  int  m_xq[$];
  int  m_yq[$];
  bit  m_run;
  int  m_idx, m_w, m_n;
  bit  m_loop;
  int  m_x, m_y;
  bit  m_eol, m_eof, m_err;

  window_scan_counter #(.H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .x_rev(x_rev), .y_rev(y_rev), .loop(loop), .abort(abort), .step(step),
    .busy(busy), .x(x), .y(y), .eol(eol), .eof(eof), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_cycle();
    int xs, xe, ys, ye;
    m_eol = 0; m_eof = 0; m_err = 0;
    xs = int'(x_start); xe = int'(x_end); ys = int'(y_start); ye = int'(y_end);
    if (reset) begin
      m_run = 0; m_x = 0; m_y = 0;
    end else if (!m_run) begin
      if (cfg_valid) begin
        if (xs <= xe && xe < int'(H_MAX) && ys <= ye && ye < int'(V_MAX)) begin
          m_xq.delete(); m_yq.delete();
          for (int r = 0; r <= ye - ys; r++)
            for (int c = 0; c <= xe - xs; c++) begin
              m_xq.push_back(x_rev ? xe - c : xs + c);
              m_yq.push_back(y_rev ? ye - r : ys + r);
            end
          m_w = xe - xs + 1; m_n = m_xq.size(); m_loop = loop;
          m_idx = 0; m_run = 1;
          m_x = m_xq[0]; m_y = m_yq[0];
        end else begin
          m_err = 1;
        end
      end
    end else if (abort) begin
      m_run = 0;
    end else if (step) begin
      m_eol = ((m_idx % m_w) == m_w - 1);
      if (m_idx == m_n - 1) begin
        m_eof = 1;
        if (m_loop) m_idx = 0;
        else        m_run = 0;
      end else begin
        m_idx++;
      end
      if (m_run) begin m_x = m_xq[m_idx]; m_y = m_yq[m_idx]; end
    end
  endtask

  // One clock: update model, clock DUT, compare all outputs after the edge
  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check("x", int'(x), m_x);
    check("y", int'(y), m_y);
    check("eol", int'(eol), int'(m_eol));
    check("eof", int'(eof), int'(m_eof));
    check("cfg_err", int'(cfg_err), int'(m_err));
    check("busy", int'(busy), int'(m_run));
    check("cfg_ready", int'(cfg_ready), int'(!m_run));
  endtask

  task automatic idle_inputs();
    reset = 0; cfg_valid = 0; abort = 0; step = 0;
  endtask

  task automatic configure(input int xs, input int xe, input int ys, input int ye,
                           input bit xr, input bit yr, input bit lp);
    x_start = X_W'(xs); x_end = X_W'(xe); y_start = Y_W'(ys); y_end = Y_W'(ye);
    x_rev = xr; y_rev = yr; loop = lp;
    cfg_valid = 1;
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    idle_inputs();
    x_start = '0; x_end = '0; y_start = '0; y_end = '0;
    x_rev = 0; y_rev = 0; loop = 0;
    m_run = 0; m_x = 0; m_y = 0; m_idx = 0; m_w = 1; m_n = 1; m_loop = 0;
    #2;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("reset_ready", int'(cfg_ready), 1);

    // Forward 3x2 frame, step held high
    configure(0, 2, 0, 1, 0, 0, 0);
    check("fwd_first_x", int'(x), 0);
    step = 1;
    repeat (6) tick();
    step = 0;
    check("fwd_done_eof", int'(eof), 1);
    check("fwd_done_busy", int'(busy), 0);
    check("fwd_hold_x", int'(x), 2);
    check("fwd_hold_y", int'(y), 1);
    tick();

    // Reverse on both axes
    configure(10, 12, 5, 6, 1, 1, 0);
    check("rev_first_x", int'(x), 12);
    check("rev_first_y", int'(y), 6);
    step = 1;
    repeat (6) tick();
    step = 0;
    tick();

    // 1x1 looping window
    configure(0, 0, 0, 0, 0, 0, 1);
    step = 1;
    repeat (3) begin
      tick();
      check("one_eof", int'(eof), 1);
    end
    step = 0;
    abort = 1; tick(); abort = 0;

    // Rejected configurations
    configure(5, 4, 0, 0, 0, 0, 0);
    check("bad_err", int'(cfg_err), 1);
    configure(0, 240, 0, 0, 0, 0, 0);
    configure(0, 0, 3, 320, 0, 0, 0);
    tick();
    check("bad_err_clear", int'(cfg_err), 0);

    // Abort together with step at (1,0)
    configure(0, 2, 0, 1, 0, 0, 0);
    step = 1; tick();
    abort = 1; tick();
    abort = 0; step = 0;
    check("abort_x", int'(x), 1);
    check("abort_busy", int'(busy), 0);
    configure(3, 4, 7, 7, 0, 0, 0);
    check("restart_x", int'(x), 3);

    // Synchronous reset mid-run with step
    step = 1; reset = 1; tick();
    reset = 0; step = 0;
    check("rst_x", int'(x), 0);
    tick();

    // Random traffic, including edge-of-panel windows and illegal configs
    for (int i = 0; i < 4000; i++) begin
      int xs, ys;
      idle_inputs();
      if (!m_run && $urandom_range(0, 3) == 0) begin
        xs = $urandom_range(0, H_MAX - 1);
        ys = $urandom_range(0, V_MAX - 1);
        if ($urandom_range(0, 3) == 0) xs = H_MAX - 1 - $urandom_range(0, 2);
        x_start = X_W'(xs);
        y_start = Y_W'(ys);
        x_end   = X_W'(($urandom_range(0, 9) == 0) ? xs - 1 + $urandom_range(0, 20)
                                                  : xs + $urandom_range(0, 4));
        y_end   = Y_W'(($urandom_range(0, 9) == 0) ? ys - 1 : ys + $urandom_range(0, 3));
        x_rev = 1'($urandom); y_rev = 1'($urandom); loop = 1'($urandom);
        cfg_valid = 1;
      end
      step  = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 400) == 0);
      if (m_run) begin
        x_start = X_W'($urandom); x_end = X_W'($urandom);
        y_start = Y_W'($urandom); y_end = Y_W'($urandom);
        cfg_valid = 1'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
